// File: rtl/axi4_pkg.sv
// ---------------------------------------------------------------------------
// axi4_pkg
//   Shared AXI4 encodings and payload-width helpers for the axi4_buf
//   channel buffer.
//
//   Contents:
//     - burst encodings (FIXED/INCR/WRAP) and response codes
//     - packed payload widths for the AW/AR, W, B and R channels
//     - occupancy-counter and pointer widths for a FIFO of a given depth
// ---------------------------------------------------------------------------
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    // Address channel payload:
    // {id, addr, len[8], size[3], burst[2], lock, cache[4], prot[3],
    //  qos[4], region[4], user}; the fixed fields add up to 29 bits.
    function automatic int aw_w(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + 29 + user_w;
    endfunction

    // Read address channel shares the write address layout.
    function automatic int ar_w(input int id_w, input int addr_w, input int user_w);
        return aw_w(id_w, addr_w, user_w);
    endfunction

    // Write data payload: {id, data, strb[DATA/8], last, user}.
    function automatic int w_w(input int id_w, input int data_w, input int user_w);
        return id_w + data_w + data_w / 8 + 1 + user_w;
    endfunction

    // Write response payload: {id, resp[2], user}.
    function automatic int b_w(input int id_w, input int user_w);
        return id_w + 2 + user_w;
    endfunction

    // Read data payload: {id, data, resp[2], last, user}.
    function automatic int r_w(input int id_w, input int data_w, input int user_w);
        return id_w + data_w + 3 + user_w;
    endfunction

    // Occupancy counter must hold 0..depth; a bypass channel still reports
    // a 1-bit (constant zero) level.
    function automatic int lvl_w(input int depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

    // Pointer indexes 0..depth-1; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage : axi4_pkg

// File: rtl/axi4_chan_fifo.sv
// ---------------------------------------------------------------------------
// axi4_chan_fifo
//   Generic single-channel buffer used for every AXI4 channel.
//   DEPTH = 0 : pure wire (valid/ready/payload pass straight through).
//   DEPTH >= 1: circular buffer; output valid and input ready come only from
//               registered state, cutting valid->valid and ready->ready paths.
//
//   Handshake: a beat transfers on a rising edge of i_aclk where the
//   producer's valid and the consumer's ready are both high. Once o_valid is
//   high, o_valid and o_data hold until that beat is taken.
//
//   Ports:
//     i_aclk, i_areset     clock, synchronous active-high reset
//     i_valid/o_ready/i_data   push side (from the producer)
//     o_valid/i_ready/o_data   pop side (to the consumer)
//     o_lvl                current occupancy (constant 0 in bypass)
//     o_empty              high when nothing is buffered
// ---------------------------------------------------------------------------
module axi4_chan_fifo
    import axi4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [WIDTH-1:0]          i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_data,
    output logic [lvl_w(DEPTH)-1:0]   o_lvl,
    output logic                      o_empty
);

    if (DEPTH == 0) begin : g_bypass
        // Clock is structurally unused in the wire configuration.
        logic w_unused_clk;
        assign w_unused_clk = i_aclk;

        // Both directions are forced low while reset is held so neither side
        // sees a spurious handshake.
        assign o_valid = i_valid & ~i_areset;
        assign o_ready = i_ready & ~i_areset;
        assign o_data  = i_data;
        assign o_lvl   = '0;
        assign o_empty = 1'b1;
    end else begin : g_fifo
        localparam int PW = ptr_w(DEPTH);
        localparam int LW = lvl_w(DEPTH);
        localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);
        localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PW-1:0]    r_wr_ptr;
        logic [PW-1:0]    r_rd_ptr;
        logic [LW-1:0]    r_cnt;

        logic w_in_ready;
        logic w_out_valid;
        logic w_push;
        logic w_pop;

        // Ready looks only at the registered count: when full, a pop in the
        // same cycle does not open a slot, which keeps out_ready off this path.
        assign w_in_ready  = (r_cnt != FULL_CNT) && !i_areset;
        assign w_out_valid = (r_cnt != '0) && !i_areset;
        assign w_push      = i_valid && w_in_ready;
        assign w_pop       = w_out_valid && i_ready;

        always_ff @(posedge i_aclk) begin
            if (i_areset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                // Explicit wrap so non-power-of-two depths work.
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + LW'(1);
                    2'b01:   r_cnt <= r_cnt - LW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Storage carries no reset; contents are meaningless while empty.
        always_ff @(posedge i_aclk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
            end
        end

        assign o_ready = w_in_ready;
        assign o_valid = w_out_valid;
        assign o_data  = r_mem[r_rd_ptr];
        assign o_lvl   = r_cnt;
        assign o_empty = (r_cnt == '0);
    end

endmodule : axi4_chan_fifo

// File: rtl/axi4_buf.sv
// ---------------------------------------------------------------------------
// axi4_buf
//   AXI4 channel buffer between an upstream master (s_ side) and a
//   downstream slave (m_ side). Each of the five channels has its own FIFO
//   depth; depth 0 turns a channel into a wire. The block never inspects
//   IDs or reorders beats.
//
//   Handshake: on every channel a beat transfers on the rising edge of aclk
//   where valid and ready are both high; valid never waits on ready, and a
//   presented beat stays stable until taken.
//
//   Ports:
//     aclk, areset            clock, synchronous active-high reset
//     s_aw*/m_aw*             write address, master -> slave
//     s_w*/m_w*               write data,    master -> slave
//     m_b*/s_b*               write response, slave -> master
//     s_ar*/m_ar*             read address,  master -> slave
//     m_r*/s_r*               read data,     slave -> master
//     aw/w/b/ar/r_lvl         per-channel occupancy
//     idle                    all channels empty (clock-gating hint)
// ---------------------------------------------------------------------------
module axi4_buf
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 4,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 2,
    parameter int B_DEPTH    = 2,
    parameter int AR_DEPTH   = 2,
    parameter int R_DEPTH    = 2
) (
    input  logic                                              aclk,
    input  logic                                              areset,

    input  logic [aw_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH)-1:0] s_aw,
    input  logic                                              s_awvalid,
    output logic                                              s_awready,
    output logic [aw_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH)-1:0] m_aw,
    output logic                                              m_awvalid,
    input  logic                                              m_awready,

    input  logic [w_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH)-1:0]  s_w,
    input  logic                                              s_wvalid,
    output logic                                              s_wready,
    output logic [w_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH)-1:0]  m_w,
    output logic                                              m_wvalid,
    input  logic                                              m_wready,

    input  logic [b_w(ID_WIDTH, USER_WIDTH)-1:0]              m_b,
    input  logic                                              m_bvalid,
    output logic                                              m_bready,
    output logic [b_w(ID_WIDTH, USER_WIDTH)-1:0]              s_b,
    output logic                                              s_bvalid,
    input  logic                                              s_bready,

    input  logic [ar_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH)-1:0] s_ar,
    input  logic                                              s_arvalid,
    output logic                                              s_arready,
    output logic [ar_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH)-1:0] m_ar,
    output logic                                              m_arvalid,
    input  logic                                              m_arready,

    input  logic [r_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH)-1:0]  m_r,
    input  logic                                              m_rvalid,
    output logic                                              m_rready,
    output logic [r_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH)-1:0]  s_r,
    output logic                                              s_rvalid,
    input  logic                                              s_rready,

    output logic [lvl_w(AW_DEPTH)-1:0]                        aw_lvl,
    output logic [lvl_w(W_DEPTH)-1:0]                         w_lvl,
    output logic [lvl_w(B_DEPTH)-1:0]                         b_lvl,
    output logic [lvl_w(AR_DEPTH)-1:0]                        ar_lvl,
    output logic [lvl_w(R_DEPTH)-1:0]                         r_lvl,
    output logic                                              idle
);

    localparam int AW_W = aw_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int AR_W = ar_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int W_W  = w_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH);
    localparam int B_W  = b_w(ID_WIDTH, USER_WIDTH);
    localparam int R_W  = r_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

    logic w_aw_empty;
    logic w_w_empty;
    logic w_b_empty;
    logic w_ar_empty;
    logic w_r_empty;

    // Master -> slave channels.
    axi4_chan_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .i_aclk   (aclk),
        .i_areset (areset),
        .i_valid  (s_awvalid),
        .o_ready  (s_awready),
        .i_data   (s_aw),
        .o_valid  (m_awvalid),
        .i_ready  (m_awready),
        .o_data   (m_aw),
        .o_lvl    (aw_lvl),
        .o_empty  (w_aw_empty)
    );

    axi4_chan_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
        .i_aclk   (aclk),
        .i_areset (areset),
        .i_valid  (s_wvalid),
        .o_ready  (s_wready),
        .i_data   (s_w),
        .o_valid  (m_wvalid),
        .i_ready  (m_wready),
        .o_data   (m_w),
        .o_lvl    (w_lvl),
        .o_empty  (w_w_empty)
    );

    axi4_chan_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .i_aclk   (aclk),
        .i_areset (areset),
        .i_valid  (s_arvalid),
        .o_ready  (s_arready),
        .i_data   (s_ar),
        .o_valid  (m_arvalid),
        .i_ready  (m_arready),
        .o_data   (m_ar),
        .o_lvl    (ar_lvl),
        .o_empty  (w_ar_empty)
    );

    // Slave -> master channels: push side is the m_ port.
    axi4_chan_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
        .i_aclk   (aclk),
        .i_areset (areset),
        .i_valid  (m_bvalid),
        .o_ready  (m_bready),
        .i_data   (m_b),
        .o_valid  (s_bvalid),
        .i_ready  (s_bready),
        .o_data   (s_b),
        .o_lvl    (b_lvl),
        .o_empty  (w_b_empty)
    );

    axi4_chan_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r_fifo (
        .i_aclk   (aclk),
        .i_areset (areset),
        .i_valid  (m_rvalid),
        .o_ready  (m_rready),
        .i_data   (m_r),
        .o_valid  (s_rvalid),
        .i_ready  (s_rready),
        .o_data   (s_r),
        .o_lvl    (r_lvl),
        .o_empty  (w_r_empty)
    );

    assign idle = w_aw_empty & w_w_empty & w_b_empty & w_ar_empty & w_r_empty;

endmodule : axi4_buf
